apb_master_bridge: RTL and testbench

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_master_bridge.sv | 100 ++++++++++
 tb/tb_apb_master_bridge.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge: FSM state type and default bus widths.
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 8;
  localparam int APB_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_master_bridge.sv
// Request/response to APB master bridge: one outstanding transfer, wait-state
// tolerant ACCESS phase with an optional timeout that reports rsp_error.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  apb_psel,
  output logic                  apb_penable,
  output logic                  apb_pwrite,
  output logic [ADDR_WIDTH-1:0] apb_paddr,
  output logic [DATA_WIDTH-1:0] apb_pwdata,
  input  logic [DATA_WIDTH-1:0] apb_prdata,
  input  logic                  apb_pready
);

  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  apb_state_e       state;
  logic [CNT_W-1:0] wait_cnt;

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      apb_psel    <= 1'b0;
      apb_penable <= 1'b0;
      apb_pwrite  <= 1'b0;
      apb_paddr   <= '0;
      apb_pwdata  <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            apb_pwrite <= req_write;
            apb_paddr  <= req_addr;
            apb_pwdata <= req_wdata;
            apb_psel   <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          apb_penable <= 1'b1;
          wait_cnt    <= '0;
          state       <= ACCESS;
        end
        ACCESS: begin
          // pready is tested first so a completion on the threshold cycle wins
          if (apb_pready) begin
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= apb_pwrite ? '0 : apb_prdata;
            rsp_error   <= 1'b0;
            state       <= RESP;
          end else if (TIMEOUT_EN && (wait_cnt == CNT_LAST)) begin
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b1;
            state       <= RESP;
          end else if (TIMEOUT_EN) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: transaction-timeline model plus
// per-cycle comparison, directed corner cases and randomized traffic.
module tb_apb_master_bridge;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_error;
  logic [DW-1:0] rsp_rdata;
  logic          apb_psel, apb_penable, apb_pwrite, apb_pready;
  logic [AW-1:0] apb_paddr;
  logic [DW-1:0] apb_pwdata, apb_prdata;

  apb_master_bridge #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
    .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata),
    .apb_prdata(apb_prdata), .apb_pready(apb_pready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle, set by the transaction model.
  logic          exp_req_ready = 1'b1;
  logic          exp_psel = 1'b0, exp_pen = 1'b0, exp_pwrite = 1'b0;
  logic [AW-1:0] exp_paddr = '0;
  logic [DW-1:0] exp_pwdata = '0;
  logic          exp_rsp_valid = 1'b0, exp_err = 1'b0;
  logic [DW-1:0] exp_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("req_ready",  32'(req_ready),   32'(exp_req_ready));
    check("psel",       32'(apb_psel),    32'(exp_psel));
    check("penable",    32'(apb_penable), 32'(exp_pen));
    check("pwrite",     32'(apb_pwrite),  32'(exp_pwrite));
    check("paddr",      32'(apb_paddr),   32'(exp_paddr));
    check("pwdata",     32'(apb_pwdata),  32'(exp_pwdata));
    check("rsp_valid",  32'(rsp_valid),   32'(exp_rsp_valid));
    if (exp_rsp_valid) begin
      check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
      check("rsp_error", 32'(rsp_error), 32'(exp_err));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    req_valid  = 1'($urandom);
    req_write  = 1'($urandom);
    req_addr   = AW'($urandom);
    req_wdata  = DW'($urandom);
    apb_pready = 1'($urandom);
    apb_prdata = DW'($urandom);
  endtask

  task automatic set_idle_exp();
    exp_req_ready = 1'b1;
    exp_psel      = 1'b0;
    exp_pen       = 1'b0;
    exp_rsp_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid  = 1'b0;
      rsp_ready  = 1'($urandom);
      apb_pready = 1'($urandom);
      apb_prdata = DW'($urandom);
      set_idle_exp();
      cycle();
    end
  endtask

  // One transfer: slave inserts `waits` wait states (ready on ACCESS cycle waits+1),
  // response is held `rdelay` cycles before rsp_ready. Reports DUT observations.
  task automatic run_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int waits, input logic [DW-1:0] prd, input int rdelay,
                         output int acc_seen, output logic [DW-1:0] got_rdata,
                         output logic got_err);
    int n;
    logic err;
    acc_seen = 0;
    n   = (waits < T) ? waits + 1 : T;
    err = (waits >= T);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    rsp_ready = 1'($urandom); apb_pready = 1'($urandom); apb_prdata = DW'($urandom);
    set_idle_exp();
    cycle();
    scramble();
    exp_req_ready = 1'b0; exp_psel = 1'b1; exp_pen = 1'b0;
    exp_pwrite = w; exp_paddr = a; exp_pwdata = d;
    cycle();
    for (int k = 1; k <= n; k++) begin
      scramble();
      apb_pready = (k == waits + 1);
      if (k == waits + 1) apb_prdata = prd;
      exp_pen = 1'b1;
      if (apb_penable) acc_seen++;
      cycle();
    end
    exp_psel = 1'b0; exp_pen = 1'b0; exp_rsp_valid = 1'b1; exp_err = err;
    exp_rdata = (w || err) ? '0 : prd;
    got_rdata = rsp_rdata;
    got_err   = rsp_error;
    for (int j = 0; j <= rdelay; j++) begin
      scramble();
      rsp_ready = (j == rdelay);
      cycle();
    end
  endtask

  int          acc;
  logic [DW-1:0] rd;
  logic        er;

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; apb_pready = 1'b0; apb_prdata = '0;
    #1 rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    idle(2);

    // Zero-wait write
    run_txn(1'b1, 8'h00, 8'hF1, 0, 8'h00, 0, acc, rd, er);
    check("zw_access_cycles", 32'(acc), 32'd1);
    check("zw_rdata", 32'(rd), 32'h0);
    check("zw_error", 32'(er), 32'h0);

    // Read with 3 wait states
    run_txn(1'b0, 8'h3C, 8'h77, 3, 8'hA5, 0, acc, rd, er);
    check("rd3_access_cycles", 32'(acc), 32'd4);
    check("rd3_rdata", 32'(rd), 32'hA5);
    check("rd3_error", 32'(er), 32'h0);

    // Timeout, slave never ready
    run_txn(1'b0, 8'h81, 8'h00, 100, 8'h5A, 0, acc, rd, er);
    check("to_access_cycles", 32'(acc), 32'd16);
    check("to_rdata", 32'(rd), 32'h0);
    check("to_error", 32'(er), 32'h1);

    // Response backpressure for 5 cycles
    run_txn(1'b0, 8'h10, 8'h00, 1, 8'h3E, 5, acc, rd, er);
    check("bp_rdata", 32'(rd), 32'h3E);

    // Ready on the threshold cycle
    run_txn(1'b0, 8'hFE, 8'h00, 15, 8'hC3, 1, acc, rd, er);
    check("thr_access_cycles", 32'(acc), 32'd16);
    check("thr_rdata", 32'(rd), 32'hC3);
    check("thr_error", 32'(er), 32'h0);
    idle(1);

    // Reset asserted in ACCESS
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h55; req_wdata = 8'h99;
    apb_pready = 1'b0; set_idle_exp();
    cycle();
    req_valid = 1'b0; exp_req_ready = 1'b0; exp_psel = 1'b1;
    exp_pwrite = 1'b1; exp_paddr = 8'h55; exp_pwdata = 8'h99;
    cycle();
    exp_pen = 1'b1;
    cycle();
    #1 rst = 1'b1;
    exp_psel = 1'b0; exp_pen = 1'b0; exp_pwrite = 1'b0; exp_paddr = '0; exp_pwdata = '0;
    exp_rsp_valid = 1'b0; exp_req_ready = 1'b1;
    #1;
    check("rst_psel_now", 32'(apb_psel), 32'h0);
    check("rst_penable_now", 32'(apb_penable), 32'h0);
    cycle();
    cycle();
    rst = 1'b0;
    idle(3);
    run_txn(1'b0, 8'h22, 8'h00, 2, 8'h6B, 0, acc, rd, er);
    check("post_rst_rdata", 32'(rd), 32'h6B);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      int r, wt;
      r = int'($urandom_range(0, 9));
      if (r <= 6)      wt = int'($urandom_range(0, 3));
      else if (r == 7) wt = T - 1;
      else if (r == 8) wt = int'($urandom_range(T, T + 4));
      else             wt = 0;
      run_txn(1'($urandom), AW'($urandom), DW'($urandom), wt, DW'($urandom),
              int'($urandom_range(0, 3)), acc, rd, er);
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
